// File: rtl/axi_lite_mem_slave_pkg.sv
// axi_lite_pkg: shared definitions for the AXI-lite memory slave.
//   RESP_OKAY / RESP_SLVERR : AXI response codes driven on bresp / rresp
//   state_t                 : slave FSM state encoding
//   lane_count()            : number of byte lanes in a data word
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_RESP = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_RESP = 2'd3
  } state_t;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// axi_lite_mem_slave_if: single-beat AXI-lite bus between an upstream master
// (the arbiter) and the memory slave.
//   AW channel : s_awvalid/s_awready, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst
//   W channel  : s_wvalid/s_wready, s_wdata, s_wstrb, s_wlast
//   B channel  : s_bvalid/s_bready, s_bresp, s_bid
//   AR channel : s_arvalid/s_arready, s_araddr, s_arid, s_arlen, s_arsize, s_arburst
//   R channel  : s_rvalid/s_rready, s_rdata, s_rresp, s_rlast, s_rid
// Modports: master (request side), slave (responder side).
interface axi_lite_mem_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int ID_WIDTH   = 4
) ();

  logic                  s_awvalid;
  logic                  s_awready;
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic [ID_WIDTH-1:0]   s_awid;
  logic [7:0]            s_awlen;
  logic [2:0]            s_awsize;
  logic [1:0]            s_awburst;

  logic                  s_wvalid;
  logic                  s_wready;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wlast;

  logic                  s_bvalid;
  logic                  s_bready;
  logic [1:0]            s_bresp;
  logic [ID_WIDTH-1:0]   s_bid;

  logic                  s_arvalid;
  logic                  s_arready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [ID_WIDTH-1:0]   s_arid;
  logic [7:0]            s_arlen;
  logic [2:0]            s_arsize;
  logic [1:0]            s_arburst;

  logic                  s_rvalid;
  logic                  s_rready;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rlast;
  logic [ID_WIDTH-1:0]   s_rid;

  modport master (
    output s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
    output s_wvalid, s_wdata, s_wstrb, s_wlast,
    output s_bready,
    output s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst,
    output s_rready,
    input  s_awready, s_wready,
    input  s_bvalid, s_bresp, s_bid,
    input  s_arready,
    input  s_rvalid, s_rdata, s_rresp, s_rlast, s_rid
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast,
    input  s_bready,
    input  s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst,
    input  s_rready,
    output s_awready, s_wready,
    output s_bvalid, s_bresp, s_bid,
    output s_arready,
    output s_rvalid, s_rdata, s_rresp, s_rlast, s_rid
  );

endinterface

// File: rtl/axi_lite_mem_slave_mem.sv
// axi_sram_mem: synchronous byte-enabled RAM with an RD_LAT-stage read pipeline.
//   clk   : clock
//   we    : write enable; lanes with be[i]=1 are written at the clock edge
//   be    : byte enables, one per byte lane
//   waddr : write word address
//   wdata : write data
//   re    : read enable; captures mem[raddr] into the first pipeline stage
//   raddr : read word address
//   rdata : read data, valid RD_LAT edges after the re edge
// Contents and pipeline are deliberately not reset.
module axi_sram_mem
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 4096,
  parameter int RD_LAT     = 1,
  localparam int MEM_AW    = $clog2(DEPTH),
  localparam int LANES     = lane_count(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LANES-1:0]      be,
  input  logic [MEM_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [MEM_AW-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem     [DEPTH];
  logic [DATA_WIDTH-1:0] rd_pipe [RD_LAT];

  // Stage 0 only loads on a read request so the word stays put while the
  // later stages shift it toward the output.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && be[i]) begin
        mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) begin
      rd_pipe[0] <= mem[raddr];
    end
    for (int s = 1; s < RD_LAT; s++) begin
      rd_pipe[s] <= rd_pipe[s-1];
    end
  end

  assign rdata = rd_pipe[RD_LAT-1];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: single-beat AXI-lite responder backed by a word-addressed
// memory. One transaction at a time; IDs are echoed; out-of-range addresses
// and bursts (len != 0) get SLVERR and never touch memory.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : axi_lite_mem_slave_if slave modport (AW/W/B/AR/R channels)
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 4096,
  parameter int RD_LAT     = 1
) (
  input  logic clk,
  input  logic rst,
  axi_lite_mem_slave_if.slave bus
);

  localparam int MEM_AW = $clog2(DEPTH);
  localparam int LANES  = lane_count(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state;
  logic [2:0]            lat_cnt;
  logic                  rd_legal;

  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;

  logic                  idle;
  logic                  wr_both;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  wr_legal;
  logic                  rd_req_legal;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_inputs;

  // Readies are gated by rst so every output reads 0 while reset is held.
  // A complete write (AW and W both valid) takes priority over a read.
  assign idle         = (state == ST_IDLE) && !rst;
  assign wr_both      = bus.s_awvalid && bus.s_wvalid;
  assign wr_accept    = idle && wr_both;
  assign rd_accept    = idle && bus.s_arvalid && !wr_both;
  assign wr_legal     = (bus.s_awlen == 8'd0) && ({1'b0, bus.s_awaddr} < DEPTH_LIM);
  assign rd_req_legal = (bus.s_arlen == 8'd0) && ({1'b0, bus.s_araddr} < DEPTH_LIM);

  assign bus.s_awready = wr_accept;
  assign bus.s_wready  = wr_accept;
  assign bus.s_arready = rd_accept;

  assign bus.s_bvalid = bvalid_q;
  assign bus.s_bresp  = bresp_q;
  assign bus.s_bid    = bid_q;
  assign bus.s_rvalid = rvalid_q;
  assign bus.s_rdata  = rdata_q;
  assign bus.s_rresp  = rresp_q;
  assign bus.s_rlast  = rlast_q;
  assign bus.s_rid    = rid_q;

  // Size/burst/last are don't-cares for single beats; strobe bits above the
  // lane count and address bits above the RAM index are covered by legality.
  assign unused_inputs = ^{bus.s_awsize, bus.s_awburst, bus.s_wlast,
                           bus.s_arsize, bus.s_arburst, bus.s_wstrb,
                           bus.s_awaddr, bus.s_araddr};

  axi_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .RD_LAT     (RD_LAT)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept && wr_legal),
    .be    (bus.s_wstrb[LANES-1:0]),
    .waddr (bus.s_awaddr[MEM_AW-1:0]),
    .wdata (bus.s_wdata),
    .re    (rd_accept),
    .raddr (bus.s_araddr[MEM_AW-1:0]),
    .rdata (mem_rdata)
  );

  // In RD_RESP the first cycle loads the response registers from the RAM
  // pipeline output; this extra registered cycle makes rvalid rise RD_LAT+1
  // cycles after the AR handshake. The wait counter is loaded with RD_LAT-1
  // and RD_WAIT leaves on the edge where it reaches 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      rd_legal <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      bid_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rid_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_accept) begin
            bid_q    <= bus.s_awid;
            bresp_q  <= wr_legal ? RESP_OKAY : RESP_SLVERR;
            bvalid_q <= 1'b1;
            state    <= ST_WR_RESP;
          end else if (rd_accept) begin
            rid_q    <= bus.s_arid;
            rd_legal <= rd_req_legal;
            lat_cnt  <= 3'(RD_LAT - 1);
            state    <= (RD_LAT == 1) ? ST_RD_RESP : ST_RD_WAIT;
          end
        end
        ST_WR_RESP: begin
          if (bus.s_bready) begin
            bvalid_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt <= 3'd1) begin
            state <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
            rlast_q  <= 1'b1;
            rdata_q  <= rd_legal ? mem_rdata : '0;
            rresp_q  <= rd_legal ? RESP_OKAY : RESP_SLVERR;
          end else if (bus.s_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: directed self-checking bench for axi_lite_mem_slave.
// Built with RD_LAT=2 so the RD_WAIT state is exercised.
module tb_axi_lite_mem_slave;
  import axi_lite_pkg::*;

  localparam int AW     = 16;
  localparam int DW     = 24;
  localparam int IW     = 4;
  localparam int DEPTH  = 4096;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_lite_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_lite_mem_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .DEPTH      (DEPTH),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Compare one observed value against a hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive all request-side signals; AW and AR share address/id/len.
  task automatic applyStimulus(input logic awv, input logic wv, input logic arv,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [3:0] strb, input logic [IW-1:0] id,
                               input logic [7:0] len);
    bus.s_awvalid = awv;
    bus.s_wvalid  = wv;
    bus.s_arvalid = arv;
    bus.s_awaddr  = addr;
    bus.s_araddr  = addr;
    bus.s_awid    = id;
    bus.s_arid    = id;
    bus.s_awlen   = len;
    bus.s_arlen   = len;
    bus.s_wdata   = data;
    bus.s_wstrb   = strb;
    bus.s_awsize  = 3'd2;
    bus.s_arsize  = 3'd2;
    bus.s_awburst = 2'b01;
    bus.s_arburst = 2'b01;
    bus.s_wlast   = 1'b1;
  endtask

  // Full write transaction; starts and ends at a falling edge.
  task automatic writeTxn(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input logic [IW-1:0] id, input logic [7:0] len,
                          input logic [1:0] exp_resp);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, data, strb, id, len);
    #1;
    checkOutput({tag, ".awready_wready"}, {30'd0, bus.s_awready, bus.s_wready}, 32'd3);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    checkOutput({tag, ".bvalid_bresp_bid"}, {25'd0, bus.s_bvalid, bus.s_bresp, bus.s_bid},
                {25'd0, 1'b1, exp_resp, id});
    bus.s_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_bready = 1'b0;
    checkOutput({tag, ".bvalid_drop"}, {31'd0, bus.s_bvalid}, 32'd0);
  endtask

  // Full read transaction with latency check; starts and ends at a falling edge.
  task automatic readTxn(input string tag, input logic [AW-1:0] addr, input logic [IW-1:0] id,
                         input logic [7:0] len, input logic [DW-1:0] exp_data,
                         input logic [1:0] exp_resp);
    int early;
    early = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, addr, '0, '0, id, len);
    #1;
    checkOutput({tag, ".arready"}, {31'd0, bus.s_arready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    for (int k = 0; k < RD_LAT; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.s_rvalid) early++;
    end
    checkOutput({tag, ".rvalid_early"}, early, 32'd0);
    @(negedge clk);
    checkOutput({tag, ".r_beat"},
                {bus.s_rvalid, bus.s_rlast, bus.s_rresp, bus.s_rid, bus.s_rdata},
                {1'b1, 1'b1, exp_resp, id, exp_data});
    @(negedge clk);
    checkOutput({tag, ".r_hold"}, {bus.s_rvalid, 7'd0, bus.s_rdata}, {1'b1, 7'd0, exp_data});
    bus.s_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_rready = 1'b0;
    checkOutput({tag, ".r_drop"}, {bus.s_rvalid, bus.s_rlast, 6'd0, bus.s_rdata}, 32'd0);
  endtask

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout checks=%0d observed=stalled expected=finish", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cycles;
    int seen;
    bus.s_bready = 1'b0;
    bus.s_rready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0010, 24'h0, 4'h0, 4'h0, 8'h0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset.readies_valids",
                {14'd0, bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_bresp,
                 bus.s_bid, bus.s_rvalid, bus.s_rresp, bus.s_rlast, bus.s_rid}, 32'd0);
    checkOutput("reset.rdata", {8'd0, bus.s_rdata}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic write/read");
    writeTxn("t1.wr", 16'h0010, 24'hABCDEF, 4'b0111, 4'd3, 8'd0, RESP_OKAY);
    readTxn("t1.rd", 16'h0010, 4'd5, 8'd0, 24'hABCDEF, RESP_OKAY);

    $display("[TB] partial strobe");
    writeTxn("t2.wr", 16'h0010, 24'h123456, 4'b0001, 4'd1, 8'd0, RESP_OKAY);
    readTxn("t2.rd", 16'h0010, 4'd2, 8'd0, 24'hABCD56, RESP_OKAY);

    $display("[TB] illegal accesses and boundaries");
    writeTxn("t3.wr0", 16'h0000, 24'h0A0B0C, 4'b0111, 4'd2, 8'd0, RESP_OKAY);
    writeTxn("t3.wr_depth", 16'(DEPTH), 24'hFFFFFF, 4'b0111, 4'd4, 8'd0, RESP_SLVERR);
    readTxn("t3.rd0", 16'h0000, 4'd4, 8'd0, 24'h0A0B0C, RESP_OKAY);
    writeTxn("t3.wr_burst", 16'h0010, 24'h111111, 4'b0111, 4'd6, 8'd1, RESP_SLVERR);
    readTxn("t3.rd_after_burst", 16'h0010, 4'd6, 8'd0, 24'hABCD56, RESP_OKAY);
    readTxn("t3.rd_depth", 16'(DEPTH), 4'd8, 8'd0, 24'h000000, RESP_SLVERR);
    readTxn("t3.rd_burst", 16'h0010, 4'd9, 8'd1, 24'h000000, RESP_SLVERR);
    writeTxn("t3.wr_last", 16'(DEPTH-1), 24'h765432, 4'b0111, 4'd9, 8'd0, RESP_OKAY);
    readTxn("t3.rd_last", 16'(DEPTH-1), 4'd10, 8'd0, 24'h765432, RESP_OKAY);
    writeTxn("t3.wr_nostrb", 16'h0010, 24'hFFFFFF, 4'b0000, 4'd11, 8'd0, RESP_OKAY);
    writeTxn("t3.wr_lane3", 16'h0010, 24'hFFFFFF, 4'b1000, 4'd12, 8'd0, RESP_OKAY);
    readTxn("t3.rd_nostrb", 16'h0010, 4'd11, 8'd0, 24'hABCD56, RESP_OKAY);

    $display("[TB] write wins over simultaneous read");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0020, 24'h13579B, 4'b0111, 4'hA, 8'd0);
    #1;
    checkOutput("t4.accept", {29'd0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'b110);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0020, 24'h0, 4'b0, 4'hA, 8'd0);
    #1;
    checkOutput("t4.wr_resp", {30'd0, bus.s_bvalid, bus.s_arready}, 32'b10);
    bus.s_bready = 1'b1;
    #1;
    checkOutput("t4.no_accept_on_b", {31'd0, bus.s_arready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.s_bready = 1'b0;
    #1;
    checkOutput("t4.read_accept", {30'd0, bus.s_bvalid, bus.s_arready}, 32'b01);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    cycles = 1;
    while (!bus.s_rvalid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("t4.rd_latency", cycles, RD_LAT + 1);
    checkOutput("t4.r_beat", {bus.s_rresp, 2'd0, bus.s_rid, bus.s_rdata},
                {RESP_OKAY, 2'd0, 4'hA, 24'h13579B});
    bus.s_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_rready = 1'b0;

    $display("[TB] B backpressure");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0030, 24'h2468AC, 4'b0111, 4'hC, 8'd0);
    #1;
    checkOutput("t5.accept", {30'd0, bus.s_awready, bus.s_wready}, 32'd3);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0031, 24'h999999, 4'b0111, 4'hD, 8'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput("t5.hold",
                  {22'd0, bus.s_bvalid, bus.s_bresp, bus.s_bid,
                   bus.s_awready, bus.s_wready, bus.s_arready},
                  {22'd0, 1'b1, RESP_OKAY, 4'hC, 3'b000});
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    bus.s_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s_bready = 1'b0;
    checkOutput("t5.bvalid_drop", {31'd0, bus.s_bvalid}, 32'd0);
    readTxn("t5.rd", 16'h0030, 4'hC, 8'd0, 24'h2468AC, RESP_OKAY);

    $display("[TB] reset during read wait");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010, 24'h0, 4'b0, 4'h3, 8'd0);
    #1;
    checkOutput("t6.arready", {31'd0, bus.s_arready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    rst = 1'b1;
    #1;
    checkOutput("t6.in_reset", {30'd0, bus.s_rvalid, bus.s_rlast}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.s_rvalid) seen++;
    end
    checkOutput("t6.discarded", seen, 32'd0);
    readTxn("t6.rd", 16'h0010, 4'h7, 8'd0, 24'hABCD56, RESP_OKAY);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
